nv_blkbox_tie_ctrl: RTL

Programmable tie-off controller for a bank of `N` constant-source outputs. By default every output behaves as a constant-0 source. Configuration software or a debug master can stage per-bit override values through a valid/ready port. A commit then applies all staged values atomically after a fixed settle interval. The block sits beside the blackbox source cells in the vlibs layer and drives ECO/spare tie nets that must change only in a controlled, glitch-free, all-at-once manner.

---
 rtl/nv_blkbox_tie_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/nv_blkbox_tie_ctrl.sv
// Tie-off controller: per-bit override values are staged into a shadow register,
// then copied to the tie outputs in one atomic update after a fixed settle interval.
module nv_blkbox_tie_ctrl #(
  parameter int N      = 8,
  parameter int IDX_W  = 3,
  parameter int SETTLE = 4
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_val,
  input  logic             cfg_commit,
  output logic [N-1:0]     tie_out,
  output logic             busy,
  output logic             commit_done,
  output logic             cfg_err
);

  localparam int CNT_W = 4;
  localparam logic [IDX_W:0] N_LIM = (IDX_W+1)'(N);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SETTLE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     shadow;
  logic             accept;
  logic             apply;
  logic             in_range;

  assign in_range = ({1'b0, cfg_idx} < N_LIM);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) state <= S_IDLE;
    else                state <= state_nxt;
  end

  // Ready/busy depend only on state, so there is no path from cfg_valid to cfg_ready.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    apply     = 1'b0;
    case (state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        accept    = cfg_valid;
        if (cfg_valid && cfg_commit) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (cnt == '0) begin
          apply     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      cnt         <= '0;
      shadow      <= '0;
      tie_out     <= '0;
      commit_done <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err     <= accept && !in_range;
      commit_done <= apply;
      // Out-of-range indices match no bit, so the shadow is left untouched.
      for (int i = 0; i < N; i++) begin
        if (accept && (cfg_idx == IDX_W'(i))) shadow[i] <= cfg_val;
      end
      if (accept && cfg_commit)
        cnt <= CNT_W'(SETTLE - 1);
      else if (state == S_SETTLE && cnt != '0)
        cnt <= cnt - CNT_W'(1);
      // Single atomic update of every tie bit.
      if (apply) tie_out <= shadow;
    end
  end

endmodule
